// File: rtl/tc_pkg.sv
// Shared definitions for timer_counter: register offsets, CTRL bit fields,
// mode encodings and FSM state encodings.
package tc_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a maskable IRQ.
// Optional build macro TC_READ_STATE_EN exposes FSM state and irq flag in CTRL reads.
module timer_counter
  import tc_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_flag_q;
  state_e      state_q;

  logic        sel_s;
  logic        wr_s;
  logic [31:0] dout_s;
  logic        unused_s;

  assign sel_s    = (Addr[31:4] == BASE[31:4]);
  assign wr_s     = WE & sel_s;
  assign unused_s = ^Addr[1:0];

  // Counter FSM plus bus register writes; bus writes come last so they win over FSM updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_q[CTRL_EN]) begin
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_q[CTRL_EN]) begin
            state_q <= S_IDLE;
          end else if (count_q == 32'd0) begin
            state_q    <= S_INT;
            irq_flag_q <= 1'b1;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        S_INT: begin
          case (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB])
            MODE_RELOAD: begin
              state_q    <= S_LOAD;
              irq_flag_q <= 1'b0;
            end
            MODE_ONESHOT: begin
              ctrl_q[CTRL_EN] <= 1'b0;
              state_q         <= S_IDLE;
            end
            default: begin
              ctrl_q[CTRL_EN] <= 1'b0;
              state_q         <= S_IDLE;
            end
          endcase
        end
        default: state_q <= S_IDLE;
      endcase

      // A CTRL or PRESET write doubles as interrupt acknowledge.
      if (wr_s) begin
        case (Addr[3:2])
          REG_CTRL: begin
            ctrl_q     <= Din[3:0];
            irq_flag_q <= 1'b0;
          end
          REG_PRESET: begin
            preset_q   <= Din;
            irq_flag_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Combinational read mux; unselected or reserved addresses return zero.
  always_comb begin
    dout_s = 32'd0;
    if (sel_s) begin
      case (Addr[3:2])
        REG_CTRL: begin
          dout_s = {28'd0, ctrl_q};
`ifdef TC_READ_STATE_EN
          dout_s[6:4] = {irq_flag_q, state_q};
`endif
        end
        REG_PRESET: dout_s = preset_q;
        REG_COUNT:  dout_s = count_q;
        default:    dout_s = 32'd0;
      endcase
    end else begin
      dout_s = 32'd0;
    end
  end

  assign Dout = dout_s;
  assign IRQ  = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expected values are queued as each
// read/IRQ sample is issued and popped when the DUT output is sampled.
module tb_timer_counter;

  localparam logic [31:0] BASE    = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL  = BASE + 32'h0;
  localparam logic [31:0] A_PRE   = BASE + 32'h4;
  localparam logic [31:0] A_CNT   = BASE + 32'h8;
  localparam logic [31:0] A_RES   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  timer_counter #(.BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Addr = 32'd0;
    Din  = 32'd0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sb_q.push_back(exp);
    Addr = a;
    #1;
    chk(tag, Dout, sb_q.pop_front());
    Addr = 32'd0;
  endtask

  task automatic irq_is(input string tag, input logic exp);
    sb_q.push_back({31'd0, exp});
    #1;
    chk(tag, {31'd0, IRQ}, sb_q.pop_front());
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] ctrl_exp(input logic [3:0] c, input logic [1:0] st, input logic fl);
    logic [31:0] v;
    v = {28'd0, c};
`ifdef TC_READ_STATE_EN
    v[6:4] = {fl, st};
`else
    v = v | ({31'd0, fl} & 32'd0) | ({30'd0, st} & 32'd0);
`endif
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 32'd0;
    Din   = 32'd0;

    // Power-on reset
    step(2);
    rd("rst_ctrl", A_CTRL, 32'd0);
    irq_is("rst_irq", 1'b0);
    reset = 1'b0;
    step(1);
    rd("rst_pre", A_PRE, 32'd0);
    rd("rst_cnt", A_CNT, 32'd0);
    rd("rst_res", A_RES, 32'd0);

    // One-shot: PRESET=3, CTRL=1001 at e0
    step(1);
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h9);
    irq_is("os_irq_e0", 1'b0);
    step(2); rd("os_cnt3", A_CNT, 32'd3);
    step(1); rd("os_cnt2", A_CNT, 32'd2);
    step(1); rd("os_cnt1", A_CNT, 32'd1);
    step(1); rd("os_cnt0", A_CNT, 32'd0); irq_is("os_irq_e5", 1'b0);
    step(1); irq_is("os_irq_e6", 1'b1);
    step(1); irq_is("os_irq_e7", 1'b1); rd("os_ctrl", A_CTRL, ctrl_exp(4'h8, 2'd0, 1'b1));
    step(2); irq_is("os_irq_hold", 1'b1);

    // Acknowledge via PRESET write, then via CTRL write
    step(1);
    wr(A_PRE, 32'd3);
    irq_is("ack_pre", 1'b0);
    rd("ack_ctrl", A_CTRL, ctrl_exp(4'h8, 2'd0, 1'b0));
    step(1);
    wr(A_CTRL, 32'h9);
    step(6); irq_is("ack_rearm", 1'b1);
    step(1);
    wr(A_CTRL, 32'h0);
    irq_is("ack_ctrl0", 1'b0);
    step(2); irq_is("ack_ctrl0_hold", 1'b0);

    // Auto-reload: PRESET=2, CTRL=1011, period 5
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      logic [31:0] ce;
      logic        ie;
      step(1);
      ce = 32'd0;
      if (k >= 2) begin
        case ((k - 2) % 5)
          0: ce = 32'd2;
          1: ce = 32'd1;
          default: ce = 32'd0;
        endcase
      end
      ie = (k >= 5) && (((k - 5) % 5) == 0);
      rd($sformatf("ar_cnt_%0d", k), A_CNT, ce);
      irq_is($sformatf("ar_irq_%0d", k), ie);
    end
    step(1);
    wr(A_CTRL, 32'h0);
    step(2);

    // Mask: IM=0, flag sets internally but IRQ stays low
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      irq_is($sformatf("msk_irq_%0d", k), 1'b0);
      if (k == 2) rd("msk_cnt1", A_CNT, 32'd1);
    end
    rd("msk_ctrl", A_CTRL, ctrl_exp(4'h0, 2'd0, 1'b1));
    step(1);
    wr(A_CTRL, 32'h8);
    irq_is("msk_clr0", 1'b0);
    step(2); irq_is("msk_clr2", 1'b0);
    rd("msk_ctrl8", A_CTRL, ctrl_exp(4'h8, 2'd0, 1'b0));

    // Decode: write just past the block, and to COUNT / reserved
    step(1);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    wr(A_RES, 32'hFFFF_FFFF);
    rd("dec_ctrl", A_CTRL, ctrl_exp(4'h8, 2'd0, 1'b0));
    rd("dec_pre", A_PRE, 32'd1);
    rd("dec_unsel", BASE + 32'h14, 32'd0);
    step(1);
    rd("dec_res", A_RES, 32'd0);

    // Disable mid-count at 7, then re-enable with PRESET=9
    step(1);
    wr(A_PRE, 32'd20);
    wr(A_CTRL, 32'h1);
    step(14);
    wr(A_CTRL, 32'h0);
    rd("dis_cnt7", A_CNT, 32'd7);
    wr(A_CNT, 32'h55);
    step(3); rd("dis_hold", A_CNT, 32'd7);
    step(1);
    wr(A_PRE, 32'd9);
    wr(A_CTRL, 32'h1);
    step(1); rd("ren_load", A_CNT, 32'd7);
    step(1); rd("ren_cnt9", A_CNT, 32'd9);
    step(1); rd("ren_cnt8", A_CNT, 32'd8);
    step(1);
    wr(A_CTRL, 32'h0);
    step(2);

    // Reset asserted mid-count at COUNT=5
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h9);
    step(7);
    rd("mid_cnt5", A_CNT, 32'd5);
    #1 reset = 1'b1;
    irq_is("mid_rst_irq", 1'b0);
    rd("mid_rst_cnt", A_CNT, 32'd0);
    step(1);
    rd("mid_rst_ctrl", A_CTRL, 32'd0);
    rd("mid_rst_pre", A_PRE, 32'd0);
    reset = 1'b0;
    step(3);
    rd("post_rst_cnt", A_CNT, 32'd0);
    irq_is("post_rst_irq", 1'b0);
    rd("post_rst_ctrl", A_CTRL, ctrl_exp(4'h0, 2'd0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
